regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised multi-port register file with an integrated write-pending scoreboard for the pipelined 32-bit processor datapath. It provides two combinational read ports, one clocked write-back port and an issue port that marks destination registers as pending. Register 0 is hardwired to zero. Optional write-to-read bypass lets the decode stage see write-back data in the same cycle.

## Interface
- `DATA_W`, 32: register width in bits.
- `ADDR_W`, 5: register address width; depth = 2**`ADDR_W`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rd_reg1`, `rd_reg2`  in  `ADDR_W`  read addresses.
- `rd_data1`, `rd_data2`  out  `DATA_W`  read data; combinational.
- `rd_busy1`, `rd_busy2`  out  1  scoreboard pending bit of the addressed register; combinational.
- `stall`  out  1  `rd_busy1 | rd_busy2`.
- `iss_valid`  in  1  issue strobe: mark `iss_reg` pending.
- `iss_reg`  in  `ADDR_W`  destination of the issued instruction.
- `wr_en`  in  1  write-back strobe.
- `wr_reg`  in  `ADDR_W`  write-back address.
- `wr_data`  in  `DATA_W`  write-back data.
- `pend_cnt`  out  `ADDR_W`+1  number of registers currently pending; registered.
- `iss_err`  out  1  one-cycle registered pulse on an illegal issue.

## Operation
- Storage: 2**`ADDR_W` x `DATA_W` registers, plus one busy bit per register.
- Reads: address 0 returns 0 with busy 0. Otherwise the port returns stored data and the stored busy bit.
- Write: `wr_en` with `wr_reg`≠0 stores `wr_data` at the clock edge and clears `busy[wr_reg]`. Writes to register 0 are ignored.
- Issue: `iss_valid` with `iss_reg`≠0 sets `busy[iss_reg]`. Issue to register 0 is ignored: no busy bit, no count change.
- Illegal issue: `iss_valid` to a register whose busy bit is already 1, and that register is not being written back this cycle.
  - The busy bit stays 1.
  - `pend_cnt` is unchanged.
  - `iss_err`=1 for the next cycle.
- Same-register issue and write-back in one cycle: the data is committed and the busy bit ends at 1 (the new issue wins). `pend_cnt` is unchanged. `iss_err` is not raised.
- Issue and write-back to different registers in one cycle: `pend_cnt` is unchanged.
- `pend_cnt` rules:
  - +1 on a legal issue that sets a cleared bit.
  - −1 on a write-back that clears a set bit.
  - A write-back to a non-busy register is legal (unscoreboarded write) and does not change the count.
  - `pend_cnt` never wraps: the maximum is 2**`ADDR_W`−1, because register 0 is excluded.

## Timing
- Read data and busy flags are combinational from address and state; zero-cycle latency.
- Without bypass, a write or issue becomes visible on the read ports the cycle after the edge.
- Reset, asynchronous on `rst_n` low:
  - all registers, busy bits, `pend_cnt` and `iss_err` go to 0 immediately;
  - therefore `rd_data*`=0, `rd_busy*`=0 and `stall`=0.
- Reset asserted mid-operation discards all pending state. No write completes on an edge while `rst_n`=0.
- Release of `rst_n` is synchronised externally; the first update is on the first edge with `rst_n`=1.

## Configuration
- `REGFILE_BYPASS_EN` defined, and a read port matches `wr_reg`≠0 while `wr_en`=1:
  - the port returns `wr_data` combinationally;
  - its `rd_busy` is forced to 0 in that cycle.
- `REGFILE_BYPASS_EN` not defined: no forwarding. Reads always return stored state; the decode stage stalls one extra cycle on a write-back hazard.

## Test plan
- Reset: assert `rst_n`=0 mid-run with `pend_cnt`=3 -> all `rd_data`=0, `rd_busy`=0 and `pend_cnt`=0 immediately, before the next clock edge.
- Write then read: write 32'hDEAD_BEEF to r5, then read r5 on both ports next cycle -> both return 32'hDEAD_BEEF. A write of 32'h1234 to r0 -> r0 still reads 0.
- Scoreboard:
  - issue r7 -> next cycle `rd_busy1`=1 (rd_reg1=7), `stall`=1, `pend_cnt`=1;
  - write-back r7 = 32'h55 -> next cycle busy 0, `pend_cnt`=0, data 32'h55.
- Illegal and same-cycle events:
  - issue r3 twice in a row -> `iss_err`=1 for one cycle, `pend_cnt`=1;
  - same-cycle issue r3 + write-back r3 -> busy stays 1, `pend_cnt`=1, no `iss_err`.
- Bypass (with `REGFILE_BYPASS_EN`): r9 busy; write-back r9 = 32'hA5A5 while reading r9 -> same cycle returns 32'hA5A5 with `rd_busy`=0. Without the macro -> old value and busy=1 that cycle, new value next cycle.
- Count saturation (`ADDR_W`=3): issue r1..r7 -> `pend_cnt`=7. Issue r0 -> `pend_cnt` stays 7.

Source files
------------

// File: rtl/regfile_sb.sv
// ============================================================================
// Module   : regfile_sb
// Brief    : Multi-port register file with write-pending scoreboard; r0 is
//            hardwired to zero. Optional write-to-read bypass: REGFILE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_reg1,
    input  logic [ADDR_W-1:0] rd_reg2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    output logic              stall,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_reg,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_reg,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W:0]   pend_cnt,
    output logic              iss_err
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;

    logic w_wr_hit;
    logic w_iss_hit;
    logic w_same;
    logic w_illegal;
    logic w_inc;
    logic w_dec;

    always_comb begin
        w_wr_hit  = wr_en && (wr_reg != '0);
        w_iss_hit = iss_valid && (iss_reg != '0);
        w_same    = w_wr_hit && w_iss_hit && (wr_reg == iss_reg);
        w_illegal = w_iss_hit && r_busy[iss_reg] && !w_same;
        // A same-register write-back and issue hand the pending bit straight
        // from the retiring instruction to the new one, so neither counts.
        w_inc     = w_iss_hit && !r_busy[iss_reg];
        w_dec     = w_wr_hit && r_busy[wr_reg] && !w_same;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_busy   <= '0;
            pend_cnt <= '0;
            iss_err  <= 1'b0;
        end else begin
            if (w_wr_hit) begin
                r_mem[wr_reg]  <= wr_data;
                r_busy[wr_reg] <= 1'b0;
            end
            if (w_iss_hit) begin
                r_busy[iss_reg] <= 1'b1;
            end
            case ({w_inc, w_dec})
                2'b10:   pend_cnt <= pend_cnt + 1'b1;
                2'b01:   pend_cnt <= pend_cnt - 1'b1;
                default: pend_cnt <= pend_cnt;
            endcase
            iss_err <= w_illegal;
        end
    end

    logic [ADDR_W-1:0] w_rd_addr [2];
    logic [DATA_W-1:0] w_rd_data [2];
    logic              w_rd_busy [2];

    assign w_rd_addr[0] = rd_reg1;
    assign w_rd_addr[1] = rd_reg2;

    generate
        for (genvar p = 0; p < 2; p++) begin : g_rd_port
            always_comb begin
                w_rd_data[p] = '0;
                w_rd_busy[p] = 1'b0;
                if (w_rd_addr[p] != '0) begin
`ifdef REGFILE_BYPASS_EN
                    if (w_wr_hit && (wr_reg == w_rd_addr[p])) begin
                        w_rd_data[p] = wr_data;
                        w_rd_busy[p] = 1'b0;
                    end else begin
                        w_rd_data[p] = r_mem[w_rd_addr[p]];
                        w_rd_busy[p] = r_busy[w_rd_addr[p]];
                    end
`else
                    w_rd_data[p] = r_mem[w_rd_addr[p]];
                    w_rd_busy[p] = r_busy[w_rd_addr[p]];
`endif
                end
            end
        end
    endgenerate

    assign rd_data1 = w_rd_data[0];
    assign rd_data2 = w_rd_data[1];
    assign rd_busy1 = w_rd_busy[0];
    assign rd_busy2 = w_rd_busy[1];
    assign stall    = w_rd_busy[0] | w_rd_busy[1];

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// ============================================================================
// Module   : tb_regfile_sb
// Brief    : Self-checking bench for regfile_sb against an array-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 1 << AW;
    localparam int SAW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0] rd_reg1 = '0, rd_reg2 = '0, iss_reg = '0, wr_reg = '0;
    logic [DW-1:0] rd_data1, rd_data2, wr_data = '0;
    logic          rd_busy1, rd_busy2, stall, iss_err;
    logic          iss_valid = 1'b0, wr_en = 1'b0;
    logic [AW:0]   pend_cnt;

    logic [SAW-1:0] s_rd_reg1 = '0, s_rd_reg2 = '0, s_iss_reg = '0, s_wr_reg = '0;
    logic [DW-1:0]  s_rd_data1, s_rd_data2;
    logic           s_rd_busy1, s_rd_busy2, s_stall, s_iss_err;
    logic           s_iss_valid = 1'b0, s_wr_en = 1'b0;
    logic [SAW:0]   s_pend_cnt;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_reg1(rd_reg1), .rd_reg2(rd_reg2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rd_busy1(rd_busy1), .rd_busy2(rd_busy2), .stall(stall),
        .iss_valid(iss_valid), .iss_reg(iss_reg),
        .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
        .pend_cnt(pend_cnt), .iss_err(iss_err)
    );

    regfile_sb #(.DATA_W(DW), .ADDR_W(SAW)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .rd_reg1(s_rd_reg1), .rd_reg2(s_rd_reg2),
        .rd_data1(s_rd_data1), .rd_data2(s_rd_data2),
        .rd_busy1(s_rd_busy1), .rd_busy2(s_rd_busy2), .stall(s_stall),
        .iss_valid(s_iss_valid), .iss_reg(s_iss_reg),
        .wr_en(s_wr_en), .wr_reg(s_wr_reg), .wr_data('0),
        .pend_cnt(s_pend_cnt), .iss_err(s_iss_err)
    );

    int checks = 0;
    int passes = 0;

    logic [DW-1:0] m_data [N];
    bit            m_busy [N];
    bit            m_err;

    function automatic int m_cnt();
        int c = 0;
        for (int i = 0; i < N; i++) c += m_busy[i] ? 1 : 0;
        return c;
    endfunction

    function automatic logic [DW-1:0] exp_data(logic [AW-1:0] a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_reg == a) return wr_data;
`endif
        return m_data[a];
    endfunction

    function automatic logic exp_busy(logic [AW-1:0] a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_reg == a) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_data[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    // Advance one clock: the model applies the inputs presented before the edge.
    task automatic tick();
        bit wv, iv, e;
        wv = wr_en && wr_reg != 0;
        iv = iss_valid && iss_reg != 0;
        e  = iv && m_busy[iss_reg] && !(wv && wr_reg == iss_reg);
        @(posedge clk);
        #1;
        if (wv) begin
            m_data[wr_reg] = wr_data;
            m_busy[wr_reg] = 1'b0;
        end
        if (iv) m_busy[iss_reg] = 1'b1;
        m_err = e;
    endtask

    task automatic idle();
        iss_valid = 1'b0;
        wr_en     = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        rd_reg1 = 5'd3; rd_reg2 = 5'd17;
        #2;
        checks++; if (rd_data1 !== 0 || rd_data2 !== 0) $display("FAIL reset_data: got %h/%h want 0", rd_data1, rd_data2); else passes++;
        checks++; if (pend_cnt !== 0 || iss_err !== 0 || stall !== 0) $display("FAIL reset_state: cnt=%0d err=%b stall=%b want 0", pend_cnt, iss_err, stall); else passes++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        wr_en = 1'b1; wr_reg = 5'd5; wr_data = 32'hDEAD_BEEF;
        tick();
        idle(); rd_reg1 = 5'd5; rd_reg2 = 5'd5;
        #1;
        checks++; if (rd_data1 !== 32'hDEAD_BEEF || rd_data2 !== 32'hDEAD_BEEF) $display("FAIL write_read: got %h/%h want deadbeef", rd_data1, rd_data2); else passes++;
        wr_en = 1'b1; wr_reg = 5'd0; wr_data = 32'h1234;
        tick();
        idle(); rd_reg1 = 5'd0;
        #1;
        checks++; if (rd_data1 !== 0 || rd_busy1 !== 0) $display("FAIL write_r0: got %h busy %b want 0", rd_data1, rd_busy1); else passes++;
    endtask

    task automatic test_scoreboard();
        iss_valid = 1'b1; iss_reg = 5'd7;
        tick();
        idle(); rd_reg1 = 5'd7; rd_reg2 = 5'd0;
        #1;
        checks++; if (rd_busy1 !== 1 || stall !== 1 || pend_cnt !== 1) $display("FAIL issue_r7: busy=%b stall=%b cnt=%0d want 1/1/1", rd_busy1, stall, pend_cnt); else passes++;
        wr_en = 1'b1; wr_reg = 5'd7; wr_data = 32'h55;
        tick();
        idle();
        #1;
        checks++; if (rd_busy1 !== 0 || pend_cnt !== 0 || rd_data1 !== 32'h55) $display("FAIL wb_r7: busy=%b cnt=%0d data=%h want 0/0/55", rd_busy1, pend_cnt, rd_data1); else passes++;
    endtask

    task automatic test_illegal();
        iss_valid = 1'b1; iss_reg = 5'd3;
        tick();
        tick();
        idle(); rd_reg1 = 5'd3;
        #1;
        checks++; if (iss_err !== 1 || pend_cnt !== 1) $display("FAIL double_issue: err=%b cnt=%0d want 1/1", iss_err, pend_cnt); else passes++;
        tick();
        checks++; if (iss_err !== 0) $display("FAIL err_pulse: err=%b want 0", iss_err); else passes++;
        iss_valid = 1'b1; iss_reg = 5'd3; wr_en = 1'b1; wr_reg = 5'd3; wr_data = 32'h77;
        tick();
        idle();
        #1;
        checks++; if (rd_busy1 !== 1 || pend_cnt !== 1 || iss_err !== 0 || rd_data1 !== 32'h77) $display("FAIL same_cycle: busy=%b cnt=%0d err=%b data=%h want 1/1/0/77", rd_busy1, pend_cnt, iss_err, rd_data1); else passes++;
        wr_en = 1'b1; wr_reg = 5'd3; wr_data = 32'h0;
        tick();
        idle();
    endtask

    task automatic test_bypass();
        iss_valid = 1'b1; iss_reg = 5'd9;
        tick();
        idle();
        rd_reg1 = 5'd9; wr_en = 1'b1; wr_reg = 5'd9; wr_data = 32'hA5A5;
        #1;
`ifdef REGFILE_BYPASS_EN
        checks++; if (rd_data1 !== 32'hA5A5 || rd_busy1 !== 0) $display("FAIL bypass: data=%h busy=%b want a5a5/0", rd_data1, rd_busy1); else passes++;
`else
        checks++; if (rd_data1 !== m_data[9] || rd_busy1 !== 1) $display("FAIL no_bypass: data=%h busy=%b want %h/1", rd_data1, rd_busy1, m_data[9]); else passes++;
`endif
        tick();
        idle();
        #1;
        checks++; if (rd_data1 !== 32'hA5A5 || rd_busy1 !== 0) $display("FAIL bypass_next: data=%h busy=%b want a5a5/0", rd_data1, rd_busy1); else passes++;
    endtask

    task automatic test_mid_reset();
        wr_en = 1'b1; wr_reg = 5'd1; wr_data = $urandom;
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            iss_valid = 1'b1; iss_reg = 5'(i + 1);
            tick();
        end
        idle(); rd_reg1 = 5'd1; rd_reg2 = 5'd2;
        #1;
        checks++; if (pend_cnt !== 3) $display("FAIL pre_reset_cnt: got %0d want 3", pend_cnt); else passes++;
        rst_n = 1'b0;
        #1;
        checks++; if (rd_data1 !== 0 || rd_busy1 !== 0 || rd_busy2 !== 0 || stall !== 0 || pend_cnt !== 0) $display("FAIL async_reset: data=%h busy=%b%b cnt=%0d want 0", rd_data1, rd_busy1, rd_busy2, pend_cnt); else passes++;
        model_reset();
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        int bad_rd = 0;
        int bad_st = 0;
        for (int it = 0; it < 400; it++) begin
            iss_valid = ($urandom_range(0, 2) != 0);
            wr_en     = ($urandom_range(0, 2) != 0);
            iss_reg   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            wr_reg    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            wr_data   = $urandom;
            rd_reg1   = 5'($urandom_range(0, 7));
            rd_reg2   = ($urandom_range(0, 1) != 0) ? wr_reg : 5'($urandom_range(0, 31));
            #1;
            checks++;
            if (rd_data1 !== exp_data(rd_reg1) || rd_data2 !== exp_data(rd_reg2) ||
                rd_busy1 !== exp_busy(rd_reg1) || rd_busy2 !== exp_busy(rd_reg2) ||
                stall !== (exp_busy(rd_reg1) | exp_busy(rd_reg2))) begin
                if (bad_rd < 5) $display("FAIL rand_read it=%0d: r%0d=%h/%b r%0d=%h/%b want %h/%b %h/%b", it,
                    rd_reg1, rd_data1, rd_busy1, rd_reg2, rd_data2, rd_busy2,
                    exp_data(rd_reg1), exp_busy(rd_reg1), exp_data(rd_reg2), exp_busy(rd_reg2));
                bad_rd++;
            end else passes++;
            tick();
            checks++;
            if (pend_cnt !== (AW+1)'(m_cnt()) || iss_err !== m_err) begin
                if (bad_st < 5) $display("FAIL rand_state it=%0d: cnt=%0d err=%b want %0d/%b", it, pend_cnt, iss_err, m_cnt(), m_err);
                bad_st++;
            end else passes++;
        end
        idle();
    endtask

    task automatic test_saturation();
        for (int r = 1; r < 8; r++) begin
            s_iss_valid = 1'b1; s_iss_reg = 3'(r);
            tick();
            checks++; if (s_pend_cnt !== 4'(r)) $display("FAIL sat_fill r%0d: cnt=%0d want %0d", r, s_pend_cnt, r); else passes++;
        end
        s_iss_reg = 3'd0;
        tick();
        checks++; if (s_pend_cnt !== 4'd7 || s_iss_err !== 0) $display("FAIL sat_r0: cnt=%0d err=%b want 7/0", s_pend_cnt, s_iss_err); else passes++;
        s_iss_reg = 3'd4;
        tick();
        s_iss_valid = 1'b0;
        checks++; if (s_pend_cnt !== 4'd7 || s_iss_err !== 1) $display("FAIL sat_illegal: cnt=%0d err=%b want 7/1", s_pend_cnt, s_iss_err); else passes++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_scoreboard();
        test_illegal();
        test_bypass();
        test_mid_reset();
        test_random();
        test_saturation();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
